// File: rtl/btb_access_ctrl_if.sv
// btb_access_ctrl_if: fetch/resolution/array signal bundle for the BTB access controller.
// Revision: 1.0
`default_nettype none

interface btb_access_ctrl_if #(
  parameter int INDEX_BITS = 10
);
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  logic                  flush;
  logic                  is_branch;
  logic [31:0]           instr_addr;
  logic                  resolution;
  logic [31:0]           branch_addr;
  logic [31:0]           branch_target;
  logic                  arr_hit;
  logic [31:0]           arr_rd_target;
  logic                  arr_read;
  logic                  arr_write;
  logic                  arr_inval;
  logic [INDEX_BITS-1:0] arr_idx;
  logic [TAG_BITS-1:0]   arr_tag;
  logic [31:0]           arr_wr_target;
  logic [31:0]           pred_addr;
  logic                  pred_valid;
  logic                  init_busy;
  logic                  update_dropped;
  logic                  lookup_denied;

  modport master (
    output flush, is_branch, instr_addr, resolution, branch_addr, branch_target,
    output arr_hit, arr_rd_target,
    input  arr_read, arr_write, arr_inval, arr_idx, arr_tag, arr_wr_target,
    input  pred_addr, pred_valid, init_busy, update_dropped, lookup_denied
  );

  modport slave (
    input  flush, is_branch, instr_addr, resolution, branch_addr, branch_target,
    input  arr_hit, arr_rd_target,
    output arr_read, arr_write, arr_inval, arr_idx, arr_tag, arr_wr_target,
    output pred_addr, pred_valid, init_busy, update_dropped, lookup_denied
  );
endinterface

`default_nettype wire

// File: rtl/btb_access_ctrl.sv
// btb_access_ctrl: shares one BTB array port between lookups, buffered updates and the invalidate sweep.
// Revision: 1.0
`default_nettype none

module btb_access_ctrl #(
  parameter int INDEX_BITS = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  btb_access_ctrl_if.slave   bus
);
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;
  localparam int ENT_BITS = 30;
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [INDEX_BITS-1:0] r_sweep_idx;
  logic [ENT_BITS-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [31:0]           r_fifo_tgt  [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   r_rd_ptr;
  logic [PTR_BITS-1:0]   r_wr_ptr;
  logic [CNT_BITS-1:0]   r_count;
  logic [31:0]           r_pred_addr;
  logic                  r_pred_valid;
  logic                  r_dropped;
  logic                  r_denied;

  logic                  w_offer;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_run;
  logic                  w_sweep;
  logic                  w_forced;
  logic                  w_lookup;
  logic                  w_drain;
  logic                  w_enq;
  logic                  w_drop;
  logic                  w_deny;
  logic [ENT_BITS-1:0]   w_head_addr;

  // Reset and flush cycles issue no array strobes at all.
  always_comb begin
    w_offer     = bus.resolution && (bus.branch_target != 32'd0);
    w_full      = (r_count == CNT_BITS'(FIFO_DEPTH));
    w_empty     = (r_count == '0);
    w_run       = !rst && !bus.flush && (r_state == ST_RUN);
    w_sweep     = !rst && !bus.flush && (r_state == ST_INIT);
    w_forced    = w_run && w_full && w_offer;
    w_lookup    = w_run && !w_forced && bus.is_branch;
    w_drain     = w_forced || (w_run && !bus.is_branch && !w_empty);
    w_enq       = w_offer && !bus.flush && (!w_full || w_drain);
    w_drop      = w_offer && (bus.flush || (w_full && !w_drain));
    w_deny      = w_forced && bus.is_branch;
    w_head_addr = r_fifo_addr[r_rd_ptr];
  end

  assign bus.arr_read       = w_lookup;
  assign bus.arr_write      = w_drain;
  assign bus.arr_inval      = w_sweep;
  assign bus.arr_idx        = w_sweep ? r_sweep_idx :
                              w_drain ? w_head_addr[INDEX_BITS-1:0] :
                                        bus.instr_addr[INDEX_BITS+1:2];
  assign bus.arr_tag        = w_drain ? w_head_addr[ENT_BITS-1:INDEX_BITS] :
                                        bus.instr_addr[31:INDEX_BITS+2];
  assign bus.arr_wr_target  = r_fifo_tgt[r_rd_ptr];
  assign bus.pred_addr      = r_pred_addr;
  assign bus.pred_valid     = r_pred_valid;
  assign bus.init_busy      = (r_state == ST_INIT);
  assign bus.update_dropped = r_dropped;
  assign bus.lookup_denied  = r_denied;

  // Word-offset bits never reach the array.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, bus.instr_addr[1:0], bus.branch_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_sweep_idx  <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_pred_addr  <= 32'd0;
      r_pred_valid <= 1'b0;
      r_dropped    <= 1'b0;
      r_denied     <= 1'b0;
    end else begin
      r_pred_valid <= w_lookup && bus.arr_hit;
      r_pred_addr  <= (w_lookup && bus.arr_hit) ? bus.arr_rd_target : 32'd0;
      r_dropped    <= w_drop;
      r_denied     <= w_deny;
      if (bus.flush) begin
        r_state     <= ST_INIT;
        r_sweep_idx <= '0;
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_count     <= '0;
      end else begin
        if (w_sweep) begin
          r_sweep_idx <= r_sweep_idx + INDEX_BITS'(1);
          if (r_sweep_idx == {INDEX_BITS{1'b1}}) begin
            r_state <= ST_RUN;
          end
        end
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
        end
        if (w_drain) begin
          r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
        end
        case ({w_enq, w_drain})
          2'b10:   r_count <= r_count + CNT_BITS'(1);
          2'b01:   r_count <= r_count - CNT_BITS'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_addr[r_wr_ptr] <= bus.branch_addr[31:2];
      r_fifo_tgt[r_wr_ptr]  <= bus.branch_target;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_btb_access_ctrl.sv
// tb_btb_access_ctrl: directed + random stimulus against a queue-based reference model of the controller.
// Revision: 1.0
`default_nettype none

module tb_btb_access_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  btb_access_ctrl_if #(.INDEX_BITS(10)) bif ();

  btb_access_ctrl #(.INDEX_BITS(10), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  idx;
    logic [19:0] tag;
    logic [31:0] tgt;
  } ent_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
    logic        drop;
    logic        deny;
    logic        busy;
  } exp_t;

  ent_t m_q[$];
  exp_t exp_q[$];
  bit   m_run;
  int   m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit br, input logic [31:0] pc, input bit hit, input logic [31:0] at,
                       input bit res, input logic [31:0] ba, input logic [31:0] bt, input bit fl);
    bif.is_branch     = br;
    bif.instr_addr    = pc;
    bif.arr_hit       = hit;
    bif.arr_rd_target = at;
    bif.resolution    = res;
    bif.branch_addr   = ba;
    bif.branch_target = bt;
    bif.flush         = fl;
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
  endtask

  // One clock: predict strobes and next-cycle outputs, check strobes before the edge,
  // then pop the scoreboard and check the registered outputs after the edge.
  task automatic tick();
    bit   offer, full, e_rd, e_wr, e_inv, grant, drop, deny;
    int   cnt0;
    ent_t w, n;
    exp_t e, got;
    offer = bif.resolution && (bif.branch_target != 32'd0);
    n.idx = bif.branch_addr[11:2];
    n.tag = bif.branch_addr[31:12];
    n.tgt = bif.branch_target;
    {e_rd, e_wr, e_inv, grant, drop, deny} = '0;
    w    = '0;
    cnt0 = m_cnt;
    if (bif.flush) begin
      drop = offer;
      m_q.delete();
      m_run = 0;
      m_cnt = 0;
    end else if (!m_run) begin
      e_inv = 1;
      if (offer) begin
        if (m_q.size() < 4) m_q.push_back(n);
        else drop = 1;
      end
      m_cnt++;
      if (m_cnt == 1024) begin
        m_run = 1;
        m_cnt = 0;
      end
    end else begin
      full = (m_q.size() == 4);
      if (full && offer) begin
        e_wr = 1;
        w    = m_q.pop_front();
        deny = bif.is_branch;
        m_q.push_back(n);
      end else begin
        if (bif.is_branch) begin
          e_rd  = 1;
          grant = 1;
        end else if (m_q.size() != 0) begin
          e_wr = 1;
          w    = m_q.pop_front();
        end
        if (offer) m_q.push_back(n);
      end
    end
    e.valid = grant && bif.arr_hit;
    e.addr  = e.valid ? bif.arr_rd_target : 32'd0;
    e.drop  = drop;
    e.deny  = deny;
    e.busy  = !m_run;
    exp_q.push_back(e);

    #1;
    chk("arr_read", 64'(bif.arr_read), 64'(e_rd));
    chk("arr_write", 64'(bif.arr_write), 64'(e_wr));
    chk("arr_inval", 64'(bif.arr_inval), 64'(e_inv));
    if (e_inv) chk("sweep_idx", 64'(bif.arr_idx), 64'(cnt0));
    if (e_rd) begin
      chk("read_idx", 64'(bif.arr_idx), 64'(bif.instr_addr[11:2]));
      chk("read_tag", 64'(bif.arr_tag), 64'(bif.instr_addr[31:12]));
    end
    if (e_wr) begin
      chk("write_idx", 64'(bif.arr_idx), 64'(w.idx));
      chk("write_tag", 64'(bif.arr_tag), 64'(w.tag));
      chk("write_target", 64'(bif.arr_wr_target), 64'(w.tgt));
    end

    @(posedge clk);
    @(negedge clk);
    got = exp_q.pop_front();
    chk("pred_addr", 64'(bif.pred_addr), 64'(got.addr));
    chk("pred_valid", 64'(bif.pred_valid), 64'(got.valid));
    chk("update_dropped", 64'(bif.update_dropped), 64'(got.drop));
    chk("lookup_denied", 64'(bif.lookup_denied), 64'(got.deny));
    chk("init_busy", 64'(bif.init_busy), 64'(got.busy));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_run = 0;
    m_cnt = 0;
    rst   = 1'b1;
    // Requests during reset must not reach the array.
    drive(1, 32'h0040_0010, 1, 32'h1234_5678, 1, 32'h0040_0020, 32'h0040_0080, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_read", 64'(bif.arr_read), 64'd0);
    chk("rst_write", 64'(bif.arr_write), 64'd0);
    chk("rst_inval", 64'(bif.arr_inval), 64'd0);
    chk("rst_pred_addr", 64'(bif.pred_addr), 64'd0);
    chk("rst_pred_valid", 64'(bif.pred_valid), 64'd0);
    chk("rst_busy", 64'(bif.init_busy), 64'd1);
    chk("rst_drop", 64'(bif.update_dropped), 64'd0);
    chk("rst_deny", 64'(bif.lookup_denied), 64'd0);
    rst = 1'b0;
    idle();

    // Post-reset sweep, with one lookup that must not be honoured.
    for (int i = 0; i < 1030; i++) begin
      if (i == 100) drive(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0, 32'h0, 0);
      else idle();
      tick();
    end
    chk("busy_after_sweep", 64'(bif.init_busy), 64'd0);

    // Lookup hit then miss.
    drive(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0, 32'h0, 0);
    #1 chk("lookup_idx4", 64'(bif.arr_idx), 64'd4);
    tick();
    chk("hit_addr", 64'(bif.pred_addr), 64'h0040_0100);
    drive(1, 32'h0040_0010, 0, 32'h0040_0100, 0, 32'h0, 32'h0, 0);
    tick();

    // Offer during a lookup stream drains only on the idle cycle.
    drive(1, 32'h0040_0200, 1, 32'h0000_0aa0, 1, 32'h0040_0020, 32'h0040_0080, 0);
    tick();
    drive(1, 32'h0040_0204, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    tick();
    drive(1, 32'h0040_0208, 1, 32'h0000_0bb0, 0, 32'h0, 32'h0, 0);
    tick();
    idle();
    #1 chk("drain_idx8", 64'(bif.arr_idx), 64'd8);
    tick();

    // Zero target is neither queued nor dropped.
    drive(0, 32'h0, 0, 32'h0, 1, 32'h0040_0040, 32'h0, 0);
    tick();

    // Fill the FIFO under lookups, then a fifth offer forces a drain and denies the lookup.
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h0040_1000 + 32'(i * 4), 1, 32'h0000_1000 + 32'(i), 1,
            32'h0041_0000 + 32'(i * 4), 32'h0050_0000 + 32'(i * 16), 0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      tick();
    end

    // Flush in RUN with an offer: dropped, sweep restarts.
    drive(0, 32'h0, 0, 32'h0, 1, 32'h0042_0000, 32'h0060_0000, 1);
    tick();
    drive(0, 32'h0, 0, 32'h0, 1, 32'h0042_0004, 32'h0060_0004, 0);
    tick();
    drive(0, 32'h0, 0, 32'h0, 1, 32'h0042_0008, 32'h0060_0008, 0);
    tick();
    idle();
    while (m_cnt != 500) tick();
    // Flush mid-sweep discards the two pending entries.
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h0043_0000, 1, 32'h0000_0ccc, 1, 32'h0044_0000 + 32'(i * 4),
            32'h0070_0000 + 32'(i * 16), 0);
      tick();
    end
    idle();
    while (!m_run) tick();
    for (int i = 0; i < 6; i++) begin
      idle();
      tick();
    end

    // Random traffic in RUN.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, 0);
      tick();
    end
    idle();
    for (int i = 0; i < 6; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/btb_access_ctrl.md
# btb_access_ctrl

Access controller for a single-ported, 2-way BTB array. It sits between the fetch stage and the array, and shares the one array port between three requesters: fetch lookups, branch-resolution updates and an invalidate sweep. Resolution updates are buffered in a small FIFO and drain on cycles the fetch stage does not need the array. The block also sequences the post-reset and flush invalidation of every set.

## Interface
- INDEX_BITS, 10, set index width; array has 2^INDEX_BITS sets; index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]
- FIFO_DEPTH, 4, update FIFO entries (power of 2, ≥2)
- CLK  in  1  clock; all state changes on posedge
- RESET  in  1  synchronous, active-high reset
- Flush_IN  in  1  restart invalidate sweep; discard FIFO
- Is_Branch_IN  in  1  fetch requests a lookup this cycle
- Instr_Addr_IN  in  32  PC of lookup
- Resolution_IN  in  1  branch resolved; update offered
- Branch_addr_IN  in  32  PC of resolved branch
- Branch_resolved_addr_IN  in  32  resolved target
- Arr_Hit_IN  in  1  array lookup hit (combinational, same cycle as Arr_Read_OUT)
- Arr_Target_IN  in  32  array lookup target
- Arr_Read_OUT  out  1  lookup strobe
- Arr_Write_OUT  out  1  install strobe (array applies its LRU replacement)
- Arr_Inval_OUT  out  1  clear both ways of set Arr_Idx_OUT
- Arr_Idx_OUT  out  INDEX_BITS  set index
- Arr_Tag_OUT  out  32-INDEX_BITS-2  tag for read/write
- Arr_Target_OUT  out  32  target for write
- Addr_OUT  out  32  predicted target, registered
- Valid_OUT  out  1  prediction valid, registered
- Init_Busy_OUT  out  1  sweep in progress
- Update_Dropped_OUT  out  1  one-cycle pulse: offered update discarded
- Lookup_Denied_OUT  out  1  one-cycle pulse: lookup lost arbitration

## Operation
- Update offer: Resolution_IN && Branch_resolved_addr_IN != 0. Zero target is never enqueued and is not a drop.
- States: INIT, RUN. RESET → INIT, sweep counter = 0, FIFO empty. Flush_IN in either state → INIT, counter = 0, FIFO emptied. Any offer in the Flush cycle is dropped (pulse).
- INIT: each cycle Arr_Inval_OUT = 1, Arr_Idx_OUT = counter, counter++. The cycle with counter = 2^INDEX_BITS−1 is the last sweep cycle; the next state is RUN. Lookups return Valid_OUT = 0 with no Lookup_Denied pulse. Offers enqueue while not full; otherwise they are dropped.
- RUN arbitration, exactly one strobe per cycle at most:
  1. Forced drain: FIFO full and offer present → write FIFO head. A lookup that cycle is denied (Lookup_Denied_OUT pulse, Valid_OUT = 0). The offer enqueues in the same edge.
  2. Else if Is_Branch_IN → Arr_Read_OUT with index/tag from Instr_Addr_IN.
  3. Else if FIFO non-empty → write head, dequeue at edge.
- Write fields: Arr_Idx_OUT/Arr_Tag_OUT from the entry's branch address, Arr_Target_OUT = entry target.
- Lookups do not see FIFO-pending updates; there is no forwarding.
- Simultaneous enqueue and dequeue: count unchanged, order preserved (FIFO strictly in-order).
- Array strobes are combinational from state and inputs, and are all 0 while RESET = 1.

## Timing
- Reset values: Addr_OUT = 0, Valid_OUT = 0, Init_Busy_OUT = 1, pulses 0, count = 0.
- Lookup latency 1: a request granted in cycle N gives Addr_OUT = Arr_Target_IN and Valid_OUT = Arr_Hit_IN in cycle N+1. On a miss, Addr_OUT = 0.
- Non-granted or absent lookup: Addr_OUT = 0, Valid_OUT = 0 in the next cycle.
- Sweep: RESET released at edge E0 → invalidates in cycles 0…2^INDEX_BITS−1 → RUN and Init_Busy_OUT = 0 from cycle 2^INDEX_BITS (1024 by default).
- Drop/deny pulses are registered and appear one cycle after the event.
- RESET or Flush mid-sweep restarts from index 0. Pending FIFO entries are lost without pulses.

## Test plan
- Reset, then idle 1030 cycles → Arr_Inval_OUT in exactly 1024 consecutive cycles, indices 0..1023, Init_Busy_OUT falls in cycle 1024.
- RUN, Is_Branch_IN with PC 0x00400010, array returns hit/target 0x00400100 → Arr_Idx_OUT = 4, next cycle Addr_OUT = 0x00400100, Valid_OUT = 1. Array returns miss → Addr_OUT = 0, Valid_OUT = 0.
- Offer 0x00400020→0x00400080 during a continuous lookup stream, then one idle cycle → no write during the stream; write with Idx = 8, Target = 0x00400080 in the idle cycle.
- Fill FIFO with 4 offers under back-to-back lookups, then a 5th offer with a lookup → head written, Lookup_Denied_OUT pulse, Valid_OUT = 0, count stays 4, later drain in original order.
- 5 offers during INIT → first 4 kept, 5th gives Update_Dropped_OUT; after RUN, 4 writes in order on idle cycles.
- Flush_IN at sweep index 500 with 2 pending updates → sweep restarts at 0, full 1024 cycles, no writes of the discarded entries.
